// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the CPU MEM stage and the data-memory responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;

  // Responder side
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

  // CPU side
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding access, programmable wait states,
// out-of-range flagging and saturating load/store counters.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            Clk,
  input  logic            Rst,
  dmem_responder_if.slave bus,
  output logic            busy,
  output logic [15:0]     rd_count,
  output logic [15:0]     wr_count
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam logic [3:0]  WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic [15:0] mem_q [Depth];
  logic        mem_we;

  logic        req_fire, resp_fire, enter_resp;
  logic        acc_write, acc_oor;
  logic [15:0] acc_addr, acc_wdata;
  logic [ADDR_W-1:0] mem_idx;

  // With zero wait states RESP is entered on the acceptance edge itself, so the
  // access must use the live request rather than the latched copy.
  always_comb begin
    req_fire   = bus.req_valid && (state_q == StIdle);
    resp_fire  = valid_q && bus.resp_ready && (state_q == StResp);
    acc_write  = (state_q == StIdle) ? bus.req_write : write_q;
    acc_addr   = (state_q == StIdle) ? bus.req_addr  : addr_q;
    acc_wdata  = (state_q == StIdle) ? bus.req_wdata : wdata_q;
    acc_oor    = 32'(acc_addr) >= Depth;
    mem_idx    = acc_addr[ADDR_W-1:0];
    enter_resp = (state_d == StResp) && (state_q != StResp);
  end

  // State register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.req_valid) state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
      StWait:  if (wait_cnt_q == 4'd0) state_d = StResp;
      StResp:  if (bus.resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    busy           = (state_q != StIdle);
    bus.resp_valid = valid_q;
    bus.resp_err   = err_q;
    bus.resp_rdata = rdata_q;
    rd_count       = rd_count_q;
    wr_count       = wr_count_q;
  end

  // Datapath next-state: request latch, wait counter, response and counters
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    valid_d    = valid_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;

    if (req_fire) begin
      write_d    = bus.req_write;
      addr_d     = bus.req_addr;
      wdata_d    = bus.req_wdata;
      wait_cnt_d = WaitInit;
    end else if (state_q == StWait && wait_cnt_q != 4'd0) begin
      wait_cnt_d = wait_cnt_q - 4'd1;
    end

    if (enter_resp) begin
      valid_d = 1'b1;
      err_d   = acc_oor;
      rdata_d = '0;
      if (!acc_oor) begin
        if (acc_write) mem_we  = 1'b1;
        else           rdata_d = mem_q[mem_idx];
      end
    end else if (resp_fire) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = '0;
      if (!err_q) begin
        if (write_q) wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
        else         rd_count_d = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wait_cnt_q <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Word array, not reset; stores commit on RESP entry
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[mem_idx] <= acc_wdata;
  end

endmodule
